apb_reg_bank: RTL and testbench
===============================

Name: apb_reg_bank

Overview:
- APB-side register bank for CatRecognizer. Sits directly downstream of the APB access-phase FSM and consumes its registered `enable` commit pulse.
- On each commit it decodes `paddr` and performs the register write or read.
- Produces the configuration, start pulse and pixel-memory write stream for the recognizer core. Captures core status and result for readback.

Parameters:
- AMBA_WORD, 32, width of pwdata/prdata.
- AMBA_ADDR_WIDTH, 16, width of paddr; the low 8 bits are decoded.
- PIX_ADDR_WIDTH, 12, depth exponent of the image/pixel memory address.

Ports:
- pclock  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  one-cycle commit pulse from the APB FSM; access is performed on this edge.
- psel  in  1  APB select; qualifies enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  AMBA_ADDR_WIDTH  byte address; bits [7:0] decoded, upper bits must be 0.
- pwdata  in  AMBA_WORD  write data.
- prdata  out  AMBA_WORD  registered read data.
- perr  out  1  one-cycle error flag for a rejected access.
- core_busy  in  1  recognizer running.
- core_done  in  1  one-cycle completion pulse from the core.
- core_result  in  1  classification result (1=cat), valid with core_done.
- start  out  1  one-cycle start pulse to the core.
- bias  out  8  signed bias register.
- thresh  out  16  decision threshold register.
- pix_we  out  1  pixel memory write strobe.
- pix_addr  out  PIX_ADDR_WIDTH  pixel memory address.
- pix_data  out  8  pixel memory write data.

Behaviour:
- Access strobe `acc = enable & psel`. Nothing in the bank changes except on an `acc` edge, `core_done` capture, or pulse clearing.
- Reset (rst=1 at an edge) clears:
  - prdata=0, perr=0, start=0, bias=0, thresh=0, pix_we=0, pix_addr=0, pix_data=0;
  - DONE=0, RESULT=0.
- rst overrides every other event on the same edge, including an in-flight access.
- Register map (offset, access):
  - 0x00 CTRL W: bit0 START. Writing 1 asserts `start` for exactly one cycle, on the edge after the access. Reads return 0.
  - 0x04 STATUS R: bit0=core_busy, bit1=DONE, other bits 0. A read returns the current value and clears DONE on the same edge.
  - 0x08 BIAS RW: pwdata[7:0].
  - 0x0C THRESH RW: pwdata[15:0].
  - 0x10 RESULT R: bit0 = result captured at the last core_done.
  - 0x14 PIX_PTR RW: pwdata[PIX_ADDR_WIDTH-1:0] loaded into pix_addr.
  - 0x18 PIX_DATA W: pix_data<=pwdata[7:0] and pix_we=1 for one cycle. pix_addr increments by 1 on the edge after pix_we. It wraps from 2^PIX_ADDR_WIDTH-1 to 0.
- Read latency: prdata updates on the `acc` edge. It is valid the cycle after enable and holds until the next read or reset. Writes never change prdata.
- Unused bits: read as 0. Write bits outside the field widths are ignored.
- perr=1 for one cycle, with no state change, when any of these holds:
  - unmapped offset;
  - nonzero paddr upper bits;
  - write to a read-only register, or read of CTRL/PIX_DATA;
  - write to CTRL, BIAS, THRESH, PIX_PTR or PIX_DATA while core_busy=1.
- A rejected read returns prdata=0.
- DONE is sticky, set by core_done. If core_done and a STATUS read occur on the same edge:
  - the read returns DONE=0 (the pre-edge value);
  - DONE is left set, so the event is not lost.
- RESULT is updated only on core_done.
- START while core_busy=1: rejected with perr; no start pulse.
- Back-to-back PIX_DATA writes (one per APB transfer) produce consecutive addresses with no gaps.

Test Plan:
- Reset: hold rst 2 cycles mid-transfer -> all outputs 0. A subsequent STATUS read returns 0x0.
- Config write/read: write BIAS=0x000000F3, THRESH=0x00011234 -> bias=0xF3, thresh=0x1234. Readback returns 0xF3 and 0x1234.
- Pixel stream: PIX_PTR=0xFFE, then PIX_DATA writes 0x11, 0x22, 0x33 -> pix_we pulses at addresses 0xFFE, 0xFFF, 0x000. pix_addr ends at 0x001.
- Start/done: write CTRL=1 -> one-cycle start. Drive core_busy=1, then core_done with core_result=1 -> STATUS reads 0x2 then 0x0, and RESULT reads 0x1.
- Busy lockout/errors:
  - write BIAS=0x55 with core_busy=1 -> perr pulse, bias unchanged;
  - read offset 0x1C -> perr pulse, prdata=0.
- Collision: core_done coincident with a STATUS read -> the read returns bit1=0. The next STATUS read returns bit1=1.

Source files
------------

// File: rtl/apb_reg_bank.sv
// APB register bank for the CatRecognizer core: config registers, start pulse,
// pixel-memory write stream, and sticky status/result capture for readback.
module apb_reg_bank #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 16,
    parameter int unsigned PIX_ADDR_WIDTH  = 12
) (
    input  logic                       pclock,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       psel,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic                       perr,
    input  logic                       core_busy,
    input  logic                       core_done,
    input  logic                       core_result,
    output logic                       start,
    output logic [7:0]                 bias,
    output logic [15:0]                thresh,
    output logic                       pix_we,
    output logic [PIX_ADDR_WIDTH-1:0]  pix_addr,
    output logic [7:0]                 pix_data
);

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_BIAS     = 8'h08;
    localparam logic [7:0] OFF_THRESH   = 8'h0C;
    localparam logic [7:0] OFF_RESULT   = 8'h10;
    localparam logic [7:0] OFF_PIX_PTR  = 8'h14;
    localparam logic [7:0] OFF_PIX_DATA = 8'h18;

    logic [AMBA_WORD-1:0]      prdata_q,   prdata_d;
    logic                      perr_q,     perr_d;
    logic                      start_q,    start_d;
    logic [7:0]                bias_q,     bias_d;
    logic [15:0]               thresh_q,   thresh_d;
    logic                      pix_we_q,   pix_we_d;
    logic [PIX_ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
    logic [7:0]                pix_data_q, pix_data_d;
    logic                      done_q,     done_d;
    logic                      result_q,   result_d;

    logic                 acc;
    logic [7:0]           offset;
    logic                 upper_ok;
    logic                 wr_legal;
    logic                 rd_legal;
    logic                 busy_locked;
    logic                 reject;
    logic [AMBA_WORD-1:0] rd_val;

    // Write data above the widest field is deliberately ignored.
    logic unused_pwdata;
    assign unused_pwdata = ^pwdata[AMBA_WORD-1:16];

    assign acc      = enable & psel;
    assign offset   = paddr[7:0];
    assign upper_ok = ~|paddr[AMBA_ADDR_WIDTH-1:8];

    // Address decode: legality per direction, busy lockout, and read mux.
    always_comb begin
        wr_legal    = 1'b0;
        rd_legal    = 1'b0;
        busy_locked = 1'b0;
        rd_val      = '0;
        case (offset)
            OFF_CTRL: begin
                wr_legal    = 1'b1;
                busy_locked = 1'b1;
            end
            OFF_STATUS: begin
                rd_legal = 1'b1;
                rd_val   = AMBA_WORD'({done_q, core_busy});
            end
            OFF_BIAS: begin
                wr_legal    = 1'b1;
                rd_legal    = 1'b1;
                busy_locked = 1'b1;
                rd_val      = AMBA_WORD'(bias_q);
            end
            OFF_THRESH: begin
                wr_legal    = 1'b1;
                rd_legal    = 1'b1;
                busy_locked = 1'b1;
                rd_val      = AMBA_WORD'(thresh_q);
            end
            OFF_RESULT: begin
                rd_legal = 1'b1;
                rd_val   = AMBA_WORD'(result_q);
            end
            OFF_PIX_PTR: begin
                wr_legal    = 1'b1;
                rd_legal    = 1'b1;
                busy_locked = 1'b1;
                rd_val      = AMBA_WORD'(pix_addr_q);
            end
            OFF_PIX_DATA: begin
                wr_legal    = 1'b1;
                busy_locked = 1'b1;
            end
            default: ;
        endcase
        reject = ~upper_ok |
                 (pwrite ? (~wr_legal | (busy_locked & core_busy)) : ~rd_legal);
    end

    // Next-state: pulse clearing, pointer advance, access commit, done capture.
    always_comb begin
        prdata_d   = prdata_q;
        perr_d     = 1'b0;
        start_d    = 1'b0;
        bias_d     = bias_q;
        thresh_d   = thresh_q;
        pix_we_d   = 1'b0;
        pix_addr_d = pix_we_q ? pix_addr_q + PIX_ADDR_WIDTH'(1) : pix_addr_q;
        pix_data_d = pix_data_q;
        done_d     = done_q;
        result_d   = result_q;

        if (acc) begin
            if (reject) begin
                perr_d = 1'b1;
                if (!pwrite) begin
                    prdata_d = '0;
                end
            end else if (pwrite) begin
                case (offset)
                    OFF_CTRL:     start_d    = pwdata[0];
                    OFF_BIAS:     bias_d     = pwdata[7:0];
                    OFF_THRESH:   thresh_d   = pwdata[15:0];
                    OFF_PIX_PTR:  pix_addr_d = pwdata[PIX_ADDR_WIDTH-1:0];
                    OFF_PIX_DATA: begin
                        pix_data_d = pwdata[7:0];
                        pix_we_d   = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                prdata_d = rd_val;
                if (offset == OFF_STATUS) begin
                    done_d = 1'b0;
                end
            end
        end

        // A completion coinciding with a STATUS read stays pending.
        if (core_done) begin
            done_d   = 1'b1;
            result_d = core_result;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge pclock) begin
        if (rst) begin
            prdata_q   <= '0;
            perr_q     <= 1'b0;
            start_q    <= 1'b0;
            bias_q     <= '0;
            thresh_q   <= '0;
            pix_we_q   <= 1'b0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
            done_q     <= 1'b0;
            result_q   <= 1'b0;
        end else begin
            prdata_q   <= prdata_d;
            perr_q     <= perr_d;
            start_q    <= start_d;
            bias_q     <= bias_d;
            thresh_q   <= thresh_d;
            pix_we_q   <= pix_we_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign prdata   = prdata_q;
    assign perr     = perr_q;
    assign start    = start_q;
    assign bias     = bias_q;
    assign thresh   = thresh_q;
    assign pix_we   = pix_we_q;
    assign pix_addr = pix_addr_q;
    assign pix_data = pix_data_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed testbench for apb_reg_bank.
module tb_apb_reg_bank;

    logic        pclock = 1'b0;
    logic        rst;
    logic        enable;
    logic        psel;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        perr;
    logic        core_busy;
    logic        core_done;
    logic        core_result;
    logic        start;
    logic [7:0]  bias;
    logic [15:0] thresh;
    logic        pix_we;
    logic [11:0] pix_addr;
    logic [7:0]  pix_data;

    int checks = 0;
    int errors = 0;

    always #5 pclock = ~pclock;

    apb_reg_bank #(
        .AMBA_WORD(32),
        .AMBA_ADDR_WIDTH(16),
        .PIX_ADDR_WIDTH(12)
    ) dut (
        .pclock(pclock),
        .rst(rst),
        .enable(enable),
        .psel(psel),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .perr(perr),
        .core_busy(core_busy),
        .core_done(core_done),
        .core_result(core_result),
        .start(start),
        .bias(bias),
        .thresh(thresh),
        .pix_we(pix_we),
        .pix_addr(pix_addr),
        .pix_data(pix_data)
    );

    // One APB transfer (setup + access); returns 1 ns after the access edge.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic sel = 1'b1, input logic done = 1'b0, input logic res = 1'b0);
        @(negedge pclock);
        psel = sel; pwrite = wr; paddr = addr; pwdata = data; enable = 1'b0;
        @(negedge pclock);
        enable = 1'b1;
        core_done = done;
        core_result = res;
        @(posedge pclock);
        #1;
        enable = 1'b0; psel = 1'b0; core_done = 1'b0;
    endtask

    task automatic test_reset();
        xfer(1'b1, 16'h0008, 32'h7A, 1'b1, 1'b1, 1'b1);
        xfer(1'b1, 16'h000C, 32'hBEEF);
        xfer(1'b1, 16'h0014, 32'h123);
        xfer(1'b1, 16'h0018, 32'h5C);
        xfer(1'b0, 16'h0008, 32'h0);
        // CTRL write whose access edge coincides with reset
        @(negedge pclock);
        psel = 1'b1; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h1; enable = 1'b0;
        @(negedge pclock);
        enable = 1'b1; rst = 1'b1;
        @(posedge pclock);
        #1;
        enable = 1'b0; psel = 1'b0;
        @(posedge pclock);
        #1;
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected %h", prdata, 32'h0); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
        checks++; if (bias !== 8'h00) begin errors++; $display("FAIL reset_bias: got %h expected 00", bias); end
        checks++; if (thresh !== 16'h0) begin errors++; $display("FAIL reset_thresh: got %h expected 0000", thresh); end
        checks++; if (pix_we !== 1'b0) begin errors++; $display("FAIL reset_pix_we: got %b expected 0", pix_we); end
        checks++; if (pix_addr !== 12'h0) begin errors++; $display("FAIL reset_pix_addr: got %h expected 000", pix_addr); end
        checks++; if (pix_data !== 8'h0) begin errors++; $display("FAIL reset_pix_data: got %h expected 00", pix_data); end
        @(negedge pclock);
        rst = 1'b0;
        xfer(1'b0, 16'h0004, 32'h0);
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", prdata, 32'h0); end
        xfer(1'b0, 16'h0010, 32'h0);
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", prdata, 32'h0); end
    endtask

    task automatic test_config();
        xfer(1'b1, 16'h0008, 32'h000000F3);
        checks++; if (bias !== 8'hF3) begin errors++; $display("FAIL cfg_bias: got %h expected F3", bias); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL cfg_bias_perr: got %b expected 0", perr); end
        xfer(1'b1, 16'h000C, 32'h00011234);
        checks++; if (thresh !== 16'h1234) begin errors++; $display("FAIL cfg_thresh: got %h expected 1234", thresh); end
        xfer(1'b0, 16'h0008, 32'h0);
        checks++; if (prdata !== 32'hF3) begin errors++; $display("FAIL cfg_bias_rd: got %h expected %h", prdata, 32'hF3); end
        xfer(1'b0, 16'h000C, 32'h0);
        checks++; if (prdata !== 32'h1234) begin errors++; $display("FAIL cfg_thresh_rd: got %h expected %h", prdata, 32'h1234); end
        // enable without psel must be ignored
        xfer(1'b1, 16'h0008, 32'hAA, 1'b0);
        checks++; if (bias !== 8'hF3) begin errors++; $display("FAIL cfg_nosel_bias: got %h expected F3", bias); end
        checks++; if (prdata !== 32'h1234) begin errors++; $display("FAIL cfg_write_keeps_prdata: got %h expected %h", prdata, 32'h1234); end
    endtask

    task automatic test_pixel();
        logic [11:0] exp_addr [3];
        logic [7:0]  exp_data [3];
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000;
        exp_data[0] = 8'h11;   exp_data[1] = 8'h22;   exp_data[2] = 8'h33;
        xfer(1'b1, 16'h0014, 32'hFFFF_FFFE);
        checks++; if (pix_addr !== 12'hFFE) begin errors++; $display("FAIL pix_ptr: got %h expected FFE", pix_addr); end
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 16'h0018, 32'(exp_data[i]));
            checks++; if (pix_we !== 1'b1) begin errors++; $display("FAIL pix_we[%0d]: got %b expected 1", i, pix_we); end
            checks++; if (pix_addr !== exp_addr[i]) begin errors++; $display("FAIL pix_addr[%0d]: got %h expected %h", i, pix_addr, exp_addr[i]); end
            checks++; if (pix_data !== exp_data[i]) begin errors++; $display("FAIL pix_data[%0d]: got %h expected %h", i, pix_data, exp_data[i]); end
        end
        @(posedge pclock);
        #1;
        checks++; if (pix_we !== 1'b0) begin errors++; $display("FAIL pix_we_end: got %b expected 0", pix_we); end
        checks++; if (pix_addr !== 12'h001) begin errors++; $display("FAIL pix_addr_end: got %h expected 001", pix_addr); end
        xfer(1'b0, 16'h0014, 32'h0);
        checks++; if (prdata !== 32'h001) begin errors++; $display("FAIL pix_ptr_rd: got %h expected %h", prdata, 32'h1); end
    endtask

    task automatic test_start_done();
        xfer(1'b1, 16'h0000, 32'h1);
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", start); end
        @(posedge pclock);
        #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_clear: got %b expected 0", start); end
        @(negedge pclock);
        core_busy = 1'b1;
        xfer(1'b0, 16'h0004, 32'h0);
        checks++; if (prdata !== 32'h1) begin errors++; $display("FAIL status_busy: got %h expected %h", prdata, 32'h1); end
        @(negedge pclock);
        core_done = 1'b1; core_result = 1'b1;
        @(negedge pclock);
        core_done = 1'b0; core_result = 1'b0; core_busy = 1'b0;
        xfer(1'b0, 16'h0004, 32'h0);
        checks++; if (prdata !== 32'h2) begin errors++; $display("FAIL status_done: got %h expected %h", prdata, 32'h2); end
        xfer(1'b0, 16'h0004, 32'h0);
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL status_cleared: got %h expected %h", prdata, 32'h0); end
        xfer(1'b0, 16'h0010, 32'h0);
        checks++; if (prdata !== 32'h1) begin errors++; $display("FAIL result_rd: got %h expected %h", prdata, 32'h1); end
    endtask

    task automatic test_errors();
        @(negedge pclock);
        core_busy = 1'b1;
        xfer(1'b1, 16'h0008, 32'h55);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL busy_bias_perr: got %b expected 1", perr); end
        checks++; if (bias !== 8'hF3) begin errors++; $display("FAIL busy_bias_kept: got %h expected F3", bias); end
        @(posedge pclock);
        #1;
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL perr_one_cycle: got %b expected 0", perr); end
        xfer(1'b1, 16'h0000, 32'h1);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL busy_start_perr: got %b expected 1", perr); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL busy_start_pulse: got %b expected 0", start); end
        @(negedge pclock);
        core_busy = 1'b0;
        xfer(1'b0, 16'h0008, 32'h0);
        checks++; if (prdata !== 32'hF3) begin errors++; $display("FAIL err_pre_rd: got %h expected %h", prdata, 32'hF3); end
        xfer(1'b0, 16'h001C, 32'h0);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL unmapped_perr: got %b expected 1", perr); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL unmapped_prdata: got %h expected %h", prdata, 32'h0); end
        xfer(1'b0, 16'h0008, 32'h0);
        xfer(1'b1, 16'h0004, 32'hFF);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL ro_write_perr: got %b expected 1", perr); end
        checks++; if (prdata !== 32'hF3) begin errors++; $display("FAIL ro_write_prdata: got %h expected %h", prdata, 32'hF3); end
        xfer(1'b0, 16'h0108, 32'h0);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL upper_perr: got %b expected 1", perr); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL upper_prdata: got %h expected %h", prdata, 32'h0); end
        xfer(1'b0, 16'h0000, 32'h0);
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL ctrl_read_perr: got %b expected 1", perr); end
    endtask

    task automatic test_collision();
        xfer(1'b0, 16'h0004, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL collide_rd: got %h expected %h", prdata, 32'h0); end
        xfer(1'b0, 16'h0004, 32'h0);
        checks++; if (prdata !== 32'h2) begin errors++; $display("FAIL collide_next: got %h expected %h", prdata, 32'h2); end
        xfer(1'b0, 16'h0004, 32'h0);
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL collide_cleared: got %h expected %h", prdata, 32'h0); end
        xfer(1'b0, 16'h0010, 32'h0);
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL collide_result: got %h expected %h", prdata, 32'h0); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; psel = 1'b0; pwrite = 1'b0;
        paddr = 16'h0; pwdata = 32'h0;
        core_busy = 1'b0; core_done = 1'b0; core_result = 1'b0;
        repeat (2) @(posedge pclock);
        @(negedge pclock);
        rst = 1'b0;
        test_reset();
        test_config();
        test_pixel();
        test_start_done();
        test_errors();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
